parity_frame_ctrl: RTL and testbench

Sequences a serial parity datapath. It accepts parallel data words over a valid/ready handshake and shifts each word out serially, one bit per accepted output beat. After the data bits it appends the computed parity bit, then enforces an optional idle gap before the next frame. It sits between a word source and a serial consumer, and replaces ad-hoc pattern generators plus free-running wr_en pulses with a controlled, back-pressurable frame stream.

---
 rtl/parity_frame_pkg.sv | 22 ++
 rtl/parity_accum.sv | 30 +++
 rtl/parity_frame_ctrl.sv | 104 ++++++++++
 tb/tb_parity_frame_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/parity_frame_pkg.sv
// parity_frame_pkg: shared state encoding, parity polarity constants and width helper for the parity framer
package parity_frame_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2,
        GAP    = 2'd3
    } state_e;

    localparam bit PAR_EVEN = 1'b1;
    localparam bit PAR_ODD  = 1'b0;
    localparam int GAP_W    = 8;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
        return r;
    endfunction

endpackage

// File: rtl/parity_accum.sv
// parity_accum: 1-bit serial XOR accumulator with selectable even/odd parity output
module parity_accum
    import parity_frame_pkg::*;
#(
    parameter bit EVEN_PARITY = PAR_EVEN
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    input  logic d,
    output logic par
);

    logic acc_q, acc_d;

    assign par = (EVEN_PARITY == PAR_ODD) ? ~acc_q : acc_q;

    // Clear wins over accumulate so a new frame always starts from zero
    always_comb begin
        acc_d = clr ? 1'b0 : (en ? acc_q ^ d : acc_q);
    end

    // Accumulator register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) acc_q <= 1'b0;
        else        acc_q <= acc_d;
    end

endmodule

// File: rtl/parity_frame_ctrl.sv
// parity_frame_ctrl: frames parallel words into a back-pressurable serial stream with a trailing parity bit
module parity_frame_ctrl
    import parity_frame_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter bit EVEN_PARITY = 1'b1,
    parameter bit MSB_FIRST   = 1'b0,
    parameter int GAP_CYCLES  = 0,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              ser_bit,
    output logic              ser_valid,
    input  logic              ser_ready,
    output logic              ser_is_parity,
    output logic              ser_first,
    output logic              ser_last,
    output logic              busy,
    output logic [CNT_W-1:0]  frame_cnt
);

    localparam int BW = (DATA_W > 1) ? clog2(DATA_W) : 1;
    localparam logic [BW-1:0] LAST_IDX = BW'(DATA_W - 1);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] sr_q, sr_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              in_fire, beat_fire, data_bit, par_bit;

    assign in_ready      = (state_q == IDLE);
    assign busy          = (state_q != IDLE);
    assign ser_valid     = (state_q == SHIFT) || (state_q == PARITY);
    assign ser_is_parity = (state_q == PARITY);
    assign ser_last      = (state_q == PARITY);
    assign ser_first     = (state_q == SHIFT) && (bit_q == LAST_IDX);
    assign data_bit      = MSB_FIRST ? sr_q[DATA_W-1] : sr_q[0];
    assign ser_bit       = (state_q == SHIFT) ? data_bit : ((state_q == PARITY) ? par_bit : 1'b0);
    assign frame_cnt     = cnt_q;
    assign in_fire       = in_valid && in_ready;
    assign beat_fire     = ser_valid && ser_ready;

    parity_accum #(.EVEN_PARITY(EVEN_PARITY)) u_acc (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (in_fire),
        .en    (beat_fire && (state_q == SHIFT)),
        .d     (data_bit),
        .par   (par_bit)
    );

    // Frame sequencing; a stalled beat leaves every register untouched
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        bit_d   = bit_q;
        gap_d   = gap_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (in_fire) begin
                sr_d    = in_data;
                bit_d   = LAST_IDX;
                state_d = SHIFT;
            end
            SHIFT: if (beat_fire) begin
                sr_d  = MSB_FIRST ? (sr_q << 1) : (sr_q >> 1);
                bit_d = bit_q - BW'(1);
                if (bit_q == '0) state_d = PARITY;
            end
            PARITY: if (beat_fire) begin
                cnt_d   = cnt_q + CNT_W'(1);
                gap_d   = GAP_W'(GAP_CYCLES - 1);
                state_d = (GAP_CYCLES > 0) ? GAP : IDLE;
            end
            default: begin
                gap_d = gap_q - GAP_W'(1);
                if (gap_q == '0) state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops any frame in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sr_q    <= '0;
            bit_q   <= '0;
            gap_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            bit_q   <= bit_d;
            gap_q   <= gap_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_parity_frame_ctrl.sv
// tb_parity_frame_ctrl: directed checks of framing, parity polarity, bit order, stalls, gap, reset and counter wrap
module tb_parity_frame_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_tests = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // A: 4-bit, even parity, LSB first, no gap
    logic [3:0] a_data = '0;
    logic a_iv = 0, a_sr = 0, a_ir, a_sb, a_sv, a_par, a_first, a_last, a_busy;
    logic [15:0] a_cnt;
    logic [4:0] a_obs;
    assign a_obs = {a_sv, a_sb, a_first, a_par, a_last};

    // B: 4-bit, odd parity, MSB first, 2-bit counter
    logic [3:0] b_data = '0;
    logic b_iv = 0, b_sr = 0, b_ir, b_sb, b_sv, b_par, b_first, b_last, b_busy;
    logic [1:0] b_cnt;
    logic [4:0] b_obs;
    assign b_obs = {b_sv, b_sb, b_first, b_par, b_last};

    // C: 8-bit, even parity, LSB first, 3-cycle gap
    logic [7:0] c_data = '0;
    logic c_iv = 0, c_sr = 0, c_ir, c_sb, c_sv, c_par, c_first, c_last, c_busy;
    logic [15:0] c_cnt;
    logic [4:0] c_obs;
    assign c_obs = {c_sv, c_sb, c_first, c_par, c_last};

    // D: 1-bit data
    logic [0:0] d_data = '0;
    logic d_iv = 0, d_sr = 0, d_ir, d_sb, d_sv, d_par, d_first, d_last, d_busy;
    logic [15:0] d_cnt;
    logic [4:0] d_obs;
    assign d_obs = {d_sv, d_sb, d_first, d_par, d_last};

    parity_frame_ctrl #(.DATA_W(4), .EVEN_PARITY(1'b1), .MSB_FIRST(1'b0), .GAP_CYCLES(0), .CNT_W(16)) u_a (
        .clk(clk), .rst_n(rst_n), .in_data(a_data), .in_valid(a_iv), .in_ready(a_ir),
        .ser_bit(a_sb), .ser_valid(a_sv), .ser_ready(a_sr), .ser_is_parity(a_par),
        .ser_first(a_first), .ser_last(a_last), .busy(a_busy), .frame_cnt(a_cnt));

    parity_frame_ctrl #(.DATA_W(4), .EVEN_PARITY(1'b0), .MSB_FIRST(1'b1), .GAP_CYCLES(0), .CNT_W(2)) u_b (
        .clk(clk), .rst_n(rst_n), .in_data(b_data), .in_valid(b_iv), .in_ready(b_ir),
        .ser_bit(b_sb), .ser_valid(b_sv), .ser_ready(b_sr), .ser_is_parity(b_par),
        .ser_first(b_first), .ser_last(b_last), .busy(b_busy), .frame_cnt(b_cnt));

    parity_frame_ctrl #(.DATA_W(8), .EVEN_PARITY(1'b1), .MSB_FIRST(1'b0), .GAP_CYCLES(3), .CNT_W(16)) u_c (
        .clk(clk), .rst_n(rst_n), .in_data(c_data), .in_valid(c_iv), .in_ready(c_ir),
        .ser_bit(c_sb), .ser_valid(c_sv), .ser_ready(c_sr), .ser_is_parity(c_par),
        .ser_first(c_first), .ser_last(c_last), .busy(c_busy), .frame_cnt(c_cnt));

    parity_frame_ctrl #(.DATA_W(1), .EVEN_PARITY(1'b1), .MSB_FIRST(1'b0), .GAP_CYCLES(0), .CNT_W(16)) u_d (
        .clk(clk), .rst_n(rst_n), .in_data(d_data), .in_valid(d_iv), .in_ready(d_ir),
        .ser_bit(d_sb), .ser_valid(d_sv), .ser_ready(d_sr), .ser_is_parity(d_par),
        .ser_first(d_first), .ser_last(d_last), .busy(d_busy), .frame_cnt(d_cnt));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        n_tests++;
        if ({a_ir, a_sv, a_sb, a_par, a_first, a_last, a_busy} !== 7'b1000000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected %b", {a_ir, a_sv, a_sb, a_par, a_first, a_last, a_busy}, 7'b1000000);
        end
        n_tests++;
        if (a_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_cnt: got %0d expected 0", a_cnt);
        end
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_lsb_even();
        logic [4:0] exp [5];
        exp = '{5'b11100, 5'b11000, 5'b10000, 5'b11000, 5'b11011};
        a_sr = 1'b1;
        a_data = 4'b1011;
        a_iv = 1'b1;
        step();
        a_iv = 1'b0;
        for (int i = 0; i < 5; i++) begin
            n_tests++;
            if (a_obs !== exp[i] || a_cnt !== 16'd0) begin
                n_fail++;
                $display("FAIL lsb_even beat%0d: got obs=%b cnt=%0d expected obs=%b cnt=0", i + 1, a_obs, a_cnt, exp[i]);
            end
            step();
        end
        n_tests++;
        if (a_cnt !== 16'd1 || a_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL lsb_even_done: got cnt=%0d busy=%b expected cnt=1 busy=0", a_cnt, a_busy);
        end
    endtask

    task automatic test_msb_odd();
        logic [4:0] exp [5];
        exp = '{5'b11100, 5'b10000, 5'b11000, 5'b11000, 5'b10011};
        b_sr = 1'b1;
        b_data = 4'b1011;
        b_iv = 1'b1;
        step();
        b_iv = 1'b0;
        for (int i = 0; i < 5; i++) begin
            n_tests++;
            if (b_obs !== exp[i]) begin
                n_fail++;
                $display("FAIL msb_odd beat%0d: got %b expected %b", i + 1, b_obs, exp[i]);
            end
            step();
        end
        n_tests++;
        if (b_cnt !== 2'd1) begin
            n_fail++;
            $display("FAIL msb_odd_cnt: got %0d expected 1", b_cnt);
        end
    endtask

    task automatic test_backpressure();
        a_sr = 1'b1;
        a_data = 4'b1011;
        a_iv = 1'b1;
        step();
        a_iv = 1'b0;
        n_tests++;
        if (a_obs !== 5'b11100) begin
            n_fail++;
            $display("FAIL bp_beat1: got %b expected %b", a_obs, 5'b11100);
        end
        step();
        a_sr = 1'b0;
        a_iv = 1'b1;
        a_data = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            step();
            n_tests++;
            if (a_obs !== 5'b11000 || a_ir !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_stall_beat2_%0d: got obs=%b in_ready=%b expected obs=11000 in_ready=0", i, a_obs, a_ir);
            end
        end
        a_iv = 1'b0;
        a_sr = 1'b1;
        step();
        n_tests++;
        if (a_obs !== 5'b10000) begin
            n_fail++;
            $display("FAIL bp_beat3: got %b expected %b", a_obs, 5'b10000);
        end
        step();
        n_tests++;
        if (a_obs !== 5'b11000) begin
            n_fail++;
            $display("FAIL bp_beat4: got %b expected %b", a_obs, 5'b11000);
        end
        step();
        a_sr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (a_obs !== 5'b11011 || a_cnt !== 16'd1) begin
                n_fail++;
                $display("FAIL bp_parity_%0d: got obs=%b cnt=%0d expected obs=11011 cnt=1", i, a_obs, a_cnt);
            end
            if (i < 2) step();
        end
        a_sr = 1'b1;
        step();
        n_tests++;
        if (a_cnt !== 16'd2 || a_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_done: got cnt=%0d busy=%b expected cnt=2 busy=0", a_cnt, a_busy);
        end
    endtask

    task automatic test_gap();
        logic [7:0] w1;
        w1 = 8'hA5;
        c_sr = 1'b1;
        c_data = w1;
        c_iv = 1'b1;
        step();
        c_data = 8'h00;
        for (int i = 0; i < 8; i++) begin
            n_tests++;
            if (c_obs !== {1'b1, w1[i], (i == 0), 2'b00}) begin
                n_fail++;
                $display("FAIL gap_f1_beat%0d: got %b expected %b", i + 1, c_obs, {1'b1, w1[i], (i == 0), 2'b00});
            end
            step();
        end
        n_tests++;
        if (c_obs !== 5'b10011) begin
            n_fail++;
            $display("FAIL gap_f1_parity: got %b expected %b", c_obs, 5'b10011);
        end
        step();
        for (int g = 0; g < 3; g++) begin
            n_tests++;
            if ({c_ir, c_sv, c_busy} !== 3'b001) begin
                n_fail++;
                $display("FAIL gap_idle%0d: got ir/sv/busy=%b expected 001", g, {c_ir, c_sv, c_busy});
            end
            step();
        end
        n_tests++;
        if ({c_ir, c_busy} !== 2'b10) begin
            n_fail++;
            $display("FAIL gap_end: got ir/busy=%b expected 10", {c_ir, c_busy});
        end
        step();
        c_iv = 1'b0;
        for (int i = 0; i < 8; i++) begin
            n_tests++;
            if (c_obs !== {1'b1, 1'b0, (i == 0), 2'b00}) begin
                n_fail++;
                $display("FAIL gap_f2_beat%0d: got %b expected %b", i + 1, c_obs, {1'b1, 1'b0, (i == 0), 2'b00});
            end
            step();
        end
        n_tests++;
        if (c_obs !== 5'b10011) begin
            n_fail++;
            $display("FAIL gap_f2_parity: got %b expected %b", c_obs, 5'b10011);
        end
        step();
        n_tests++;
        if (c_cnt !== 16'd2) begin
            n_fail++;
            $display("FAIL gap_cnt: got %0d expected 2", c_cnt);
        end
    endtask

    task automatic test_data_w1();
        d_sr = 1'b1;
        d_data = 1'b1;
        d_iv = 1'b1;
        step();
        d_iv = 1'b0;
        n_tests++;
        if (d_obs !== 5'b11100) begin
            n_fail++;
            $display("FAIL w1_data: got %b expected %b", d_obs, 5'b11100);
        end
        step();
        n_tests++;
        if (d_obs !== 5'b11011) begin
            n_fail++;
            $display("FAIL w1_parity: got %b expected %b", d_obs, 5'b11011);
        end
        step();
        n_tests++;
        if ({d_cnt, d_busy, d_ir} !== {16'd1, 2'b01}) begin
            n_fail++;
            $display("FAIL w1_done: got cnt=%0d busy=%b ir=%b expected cnt=1 busy=0 ir=1", d_cnt, d_busy, d_ir);
        end
    endtask

    task automatic test_reset_midframe();
        logic [4:0] exp [5];
        exp = '{5'b11100, 5'b11000, 5'b11000, 5'b10000, 5'b11011};
        a_sr = 1'b1;
        a_data = 4'b1011;
        a_iv = 1'b1;
        step();
        a_iv = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({a_ir, a_sv, a_sb, a_par, a_first, a_last, a_busy} !== 7'b1000000 || a_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL midreset: got flags=%b cnt=%0d expected flags=1000000 cnt=0",
                     {a_ir, a_sv, a_sb, a_par, a_first, a_last, a_busy}, a_cnt);
        end
        step();
        rst_n = 1'b1;
        step();
        a_data = 4'b0111;
        a_iv = 1'b1;
        step();
        a_iv = 1'b0;
        for (int i = 0; i < 5; i++) begin
            n_tests++;
            if (a_obs !== exp[i] || a_cnt !== 16'd0) begin
                n_fail++;
                $display("FAIL postreset beat%0d: got obs=%b cnt=%0d expected obs=%b cnt=0", i + 1, a_obs, a_cnt, exp[i]);
            end
            step();
        end
        n_tests++;
        if (a_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL postreset_cnt: got %0d expected 1", a_cnt);
        end
    endtask

    task automatic test_back_to_back_wrap();
        logic [1:0] exp [5];
        exp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        b_sr = 1'b1;
        b_data = 4'b0101;
        b_iv = 1'b1;
        for (int f = 0; f < 5; f++) begin
            for (int k = 0; k < 6; k++) step();
            n_tests++;
            if ({b_cnt, b_busy, b_ir} !== {exp[f], 2'b01}) begin
                n_fail++;
                $display("FAIL wrap_frame%0d: got cnt=%0d busy=%b ir=%b expected cnt=%0d busy=0 ir=1", f + 1, b_cnt, b_busy, b_ir, exp[f]);
            end
        end
        b_iv = 1'b0;
    endtask

    initial begin
        test_reset();
        test_lsb_even();
        test_msb_odd();
        test_backpressure();
        test_gap();
        test_data_w1();
        test_reset_midframe();
        test_back_to_back_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
